// File: rtl/pc_pkg.sv
// Shared opcode encodings and branch-condition helpers for the PC sequencer.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    BR_NONE   = 3'b000,
    BR_ALWAYS = 3'b001,
    BR_PL     = 3'b010,
    BR_MI     = 3'b011,
    BR_Z      = 3'b100
  } branch_op_t;

  typedef enum logic [OP_W-1:0] {
    ST_NONE = 3'b000,
    ST_PUSH = 3'b001,
    ST_POP  = 3'b010,
    ST_CALL = 3'b011,
    ST_RET  = 3'b100
  } stack_op_t;

  // Reserved codes decode as "no branch" so the stack opcode still applies.
  function automatic logic is_branch_op(input logic [OP_W-1:0] op);
    return (op == BR_ALWAYS) || (op == BR_PL) || (op == BR_MI) || (op == BR_Z);
  endfunction

  function automatic logic branch_cond(input logic [OP_W-1:0] op,
                                       input logic signed [31:0] v);
    logic r;
    r = 1'b0;
    case (op)
      BR_ALWAYS: r = 1'b1;
      BR_PL:     r = (v > 0);
      BR_MI:     r = (v < 0);
      BR_Z:      r = (v == 0);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and saturating count.
// A push on a full stack overwrites the oldest entry.
module pc_ras import pc_pkg::*; #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_push_data,
  output logic [W-1:0]             o_top,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_top_idx;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_idx;

  assign w_wr_idx = r_top_idx + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_top_idx <= '0;
      r_count   <= '0;
    end else if (i_push) begin
      r_top_idx <= w_wr_idx;
      if (r_count != CW'(DEPTH))
        r_count <= r_count + 1'b1;
    end else if (i_pop && (r_count != '0)) begin
      r_top_idx <= r_top_idx - 1'b1;
      r_count   <= r_count - 1'b1;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_push)
      r_mem[w_wr_idx] <= i_push_data;
  end

  assign o_top   = r_mem[r_top_idx];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with signed branches and an on-chip return-address stack.
// Optional feature macro PC_RAS_EXC_EN: RAS overflow/underflow vectors to EXC_VECTOR and pulses o_exc.
module pc_sequencer import pc_pkg::*; #(
  parameter int              PC_W       = 32,
  parameter int              RAS_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] EXC_VECTOR = 'h10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_step,
  input  logic [OP_W-1:0]            i_branch_op,
  input  logic [OP_W-1:0]            i_stack_op,
  input  logic [PC_W-1:0]            i_target,
  input  logic [31:0]                i_regval,
  input  logic [PC_W-1:0]            i_mem_ret,
  output logic [PC_W-1:0]            o_pc,
  output logic                       o_taken,
  output logic [$clog2(RAS_DEPTH):0] o_ras_count,
  output logic                       o_ras_full,
`ifdef PC_RAS_EXC_EN
  output logic                       o_ras_empty,
  output logic                       o_exc
`else
  output logic                       o_ras_empty
`endif
);

  logic [PC_W-1:0] r_pc;
  logic            r_taken;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_next_pc;
  logic            w_next_taken;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_full;
  logic            w_ras_empty;
`ifdef PC_RAS_EXC_EN
  logic            r_exc;
  logic            w_next_exc;
`endif

  assign w_pc_inc = r_pc + 1'b1;

  // Next-PC selection; branches take priority over stack opcodes.
  always_comb begin
    w_next_pc    = w_pc_inc;
    w_next_taken = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
`ifdef PC_RAS_EXC_EN
    w_next_exc   = 1'b0;
`endif
    if (is_branch_op(i_branch_op)) begin
      if (branch_cond(i_branch_op, i_regval)) begin
        w_next_pc    = i_target;
        w_next_taken = 1'b1;
      end
    end else begin
      case (i_stack_op)
        ST_CALL: begin
          w_next_taken = 1'b1;
`ifdef PC_RAS_EXC_EN
          if (w_ras_full) begin
            w_next_pc  = EXC_VECTOR;
            w_next_exc = 1'b1;
          end else begin
            w_push    = 1'b1;
            w_next_pc = i_target;
          end
`else
          w_push    = 1'b1;
          w_next_pc = i_target;
`endif
        end
        ST_RET: begin
          w_next_taken = 1'b1;
          if (!w_ras_empty) begin
            w_pop     = 1'b1;
            w_next_pc = w_ras_top;
          end else begin
`ifdef PC_RAS_EXC_EN
            w_next_pc  = EXC_VECTOR;
            w_next_exc = 1'b1;
`else
            w_next_pc  = i_mem_ret;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push && i_step),
    .i_pop       (w_pop && i_step),
    .i_push_data (w_pc_inc),
    .o_top       (w_ras_top),
    .o_count     (o_ras_count),
    .o_full      (w_ras_full),
    .o_empty     (w_ras_empty)
  );

  // A held step keeps pc/taken but lets any exception pulse fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
`ifdef PC_RAS_EXC_EN
      r_exc   <= 1'b0;
`endif
    end else if (i_step) begin
      r_pc    <= w_next_pc;
      r_taken <= w_next_taken;
`ifdef PC_RAS_EXC_EN
      r_exc   <= w_next_exc;
`endif
    end else begin
`ifdef PC_RAS_EXC_EN
      r_exc   <= 1'b0;
`endif
    end
  end

  assign o_pc        = r_pc;
  assign o_taken     = r_taken;
  assign o_ras_full  = w_ras_full;
  assign o_ras_empty = w_ras_empty;
`ifdef PC_RAS_EXC_EN
  assign o_exc       = r_exc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (RAS_DEPTH=2, RESET_PC=5); follows PC_RAS_EXC_EN if defined.
module tb_pc_sequencer;
  import pc_pkg::*;

`ifdef PC_RAS_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam logic [31:0] EXC_VEC = 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic [2:0]  branchOp = 3'b000;
  logic [2:0]  stackOp = 3'b000;
  logic [31:0] target = '0;
  logic [31:0] regval = '0;
  logic [31:0] memRet = '0;
  logic [31:0] pc;
  logic        taken;
  logic [1:0]  rasCount;
  logic        rasFull;
  logic        rasEmpty;
  logic        exc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  cnt;
    logic        exc;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W       (32),
    .RAS_DEPTH  (2),
    .RESET_PC   (32'd5),
    .EXC_VECTOR (EXC_VEC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_step      (step),
    .i_branch_op (branchOp),
    .i_stack_op  (stackOp),
    .i_target    (target),
    .i_regval    (regval),
    .i_mem_ret   (memRet),
    .o_pc        (pc),
    .o_taken     (taken),
    .o_ras_count (rasCount),
    .o_ras_full  (rasFull),
`ifdef PC_RAS_EXC_EN
    .o_ras_empty (rasEmpty),
    .o_exc       (exc)
`else
    .o_ras_empty (rasEmpty)
`endif
  );

`ifndef PC_RAS_EXC_EN
  assign exc = 1'b0;
`endif

  task automatic checkField(input string nm, input string what,
                            input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", nm, what, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField(e.name, "pc", pc, e.pc);
    checkField(e.name, "taken", {31'b0, taken}, {31'b0, e.taken});
    checkField(e.name, "ras_count", {30'b0, rasCount}, {30'b0, e.cnt});
    checkField(e.name, "ras_full", {31'b0, rasFull}, {31'b0, (e.cnt == 2'd2)});
    checkField(e.name, "ras_empty", {31'b0, rasEmpty}, {31'b0, (e.cnt == 2'd0)});
    if (EXC_EN)
      checkField(e.name, "exc", {31'b0, exc}, {31'b0, e.exc});
  endtask

  // Monitor: every edge that follows a queued stimulus presents a result.
  always @(posedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      #1;
      checkOutput(monExp);
    end
  end

  task automatic applyStimulus(input string nm, input logic r, input logic s,
                               input logic [2:0] bop, input logic [2:0] sop,
                               input logic [31:0] tgt, input logic [31:0] rv,
                               input logic [31:0] mr, input logic [31:0] ePc,
                               input logic eTaken, input logic [1:0] eCnt,
                               input logic eExc);
    exp_t e;
    @(negedge clk);
    rst = r; step = s; branchOp = bop; stackOp = sop;
    target = tgt; regval = rv; memRet = mr;
    e.name = nm; e.pc = ePc; e.taken = eTaken; e.cnt = eCnt; e.exc = eExc;
    expQ.push_back(e);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //             name        rst  stp  branch     stack    target        regval        memret  pc            tk  cnt exc
    applyStimulus("reset",     1,   1,   BR_NONE,   ST_CALL, 32'd77,       32'd0,        32'd0,  32'd5,        0,  0,  0);
    applyStimulus("nop1",      0,   1,   BR_NONE,   ST_NONE, 32'd0,        32'd0,        32'd0,  32'd6,        0,  0,  0);
    applyStimulus("nop2",      0,   1,   BR_NONE,   ST_NONE, 32'd0,        32'd0,        32'd0,  32'd7,        0,  0,  0);
    applyStimulus("nop3",      0,   1,   BR_NONE,   ST_NONE, 32'd0,        32'd0,        32'd0,  32'd8,        0,  0,  0);
    applyStimulus("hold1",     0,   0,   BR_ALWAYS, ST_NONE, 32'd99,       32'd0,        32'd0,  32'd8,        0,  0,  0);
    applyStimulus("bpl_neg",   0,   1,   BR_PL,     ST_NONE, 32'd40,       32'hFFFFFFFF, 32'd0,  32'd9,        0,  0,  0);
    applyStimulus("bmi_neg",   0,   1,   BR_MI,     ST_NONE, 32'd40,       32'hFFFFFFFF, 32'd0,  32'd40,       1,  0,  0);
    applyStimulus("hold2",     0,   0,   BR_NONE,   ST_NONE, 32'd0,        32'd0,        32'd0,  32'd40,       1,  0,  0);
    applyStimulus("bz_zero",   0,   1,   BR_Z,      ST_NONE, 32'd3,        32'd0,        32'd0,  32'd3,        1,  0,  0);
    applyStimulus("bz_one",    0,   1,   BR_Z,      ST_NONE, 32'd3,        32'd1,        32'd0,  32'd4,        0,  0,  0);
    applyStimulus("bpl_pos",   0,   1,   BR_PL,     ST_NONE, 32'd20,       32'd1,        32'd0,  32'd20,       1,  0,  0);
    applyStimulus("bpl_zero",  0,   1,   BR_PL,     ST_NONE, 32'd50,       32'd0,        32'd0,  32'd21,       0,  0,  0);
    applyStimulus("bmi_zero",  0,   1,   BR_MI,     ST_NONE, 32'd50,       32'd0,        32'd0,  32'd22,       0,  0,  0);
    applyStimulus("bmi_min",   0,   1,   BR_MI,     ST_NONE, 32'd60,       32'h80000000, 32'd0,  32'd60,       1,  0,  0);
    applyStimulus("br_rsvd",   0,   1,   3'b111,    ST_NONE, 32'd99,       32'd0,        32'd0,  32'd61,       0,  0,  0);
    applyStimulus("br_prio",   0,   1,   BR_ALWAYS, ST_CALL, 32'd10,       32'd0,        32'd0,  32'd10,       1,  0,  0);
    applyStimulus("call100",   0,   1,   BR_NONE,   ST_CALL, 32'd100,      32'd0,        32'd0,  32'd100,      1,  1,  0);
    applyStimulus("call200",   0,   1,   BR_NONE,   ST_CALL, 32'd200,      32'd0,        32'd0,  32'd200,      1,  2,  0);
    applyStimulus("ret1",      0,   1,   BR_NONE,   ST_RET,  32'd0,        32'd0,        32'd0,  32'd101,      1,  1,  0);
    applyStimulus("ret2",      0,   1,   BR_NONE,   ST_RET,  32'd0,        32'd0,        32'd0,  32'd11,       1,  0,  0);
    applyStimulus("push",      0,   1,   BR_NONE,   ST_PUSH, 32'd0,        32'd0,        32'd0,  32'd12,       0,  0,  0);
    applyStimulus("pop",       0,   1,   BR_NONE,   ST_POP,  32'd0,        32'd0,        32'd0,  32'd13,       0,  0,  0);
    applyStimulus("st_rsvd",   0,   1,   BR_NONE,   3'b111,  32'd0,        32'd0,        32'd0,  32'd14,       0,  0,  0);
    applyStimulus("ret_empty", 0,   1,   BR_NONE,   ST_RET,  32'd0,        32'd0,        32'd777,
                  EXC_EN ? EXC_VEC : 32'd777, 1, 0, EXC_EN);
    applyStimulus("exc_hold",  0,   0,   BR_NONE,   ST_NONE, 32'd0,        32'd0,        32'd0,
                  EXC_EN ? EXC_VEC : 32'd777, 1, 0, 0);
    applyStimulus("br_zero",   0,   1,   BR_ALWAYS, ST_NONE, 32'd0,        32'd0,        32'd0,  32'd0,        1,  0,  0);
    applyStimulus("dcall1",    0,   1,   BR_NONE,   ST_CALL, 32'd100,      32'd0,        32'd0,  32'd100,      1,  1,  0);
    applyStimulus("dcall2",    0,   1,   BR_NONE,   ST_CALL, 32'd200,      32'd0,        32'd0,  32'd200,      1,  2,  0);
    applyStimulus("dcall3",    0,   1,   BR_NONE,   ST_CALL, 32'd300,      32'd0,        32'd0,
                  EXC_EN ? EXC_VEC : 32'd300, 1, 2, EXC_EN);
    applyStimulus("dret1",     0,   1,   BR_NONE,   ST_RET,  32'd0,        32'd0,        32'd55,
                  EXC_EN ? 32'd101 : 32'd201, 1, 1, 0);
    applyStimulus("dret2",     0,   1,   BR_NONE,   ST_RET,  32'd0,        32'd0,        32'd55,
                  EXC_EN ? 32'd1 : 32'd101, 1, 0, 0);
    applyStimulus("dret3",     0,   1,   BR_NONE,   ST_RET,  32'd0,        32'd0,        32'd55,
                  EXC_EN ? EXC_VEC : 32'd55, 1, 0, EXC_EN);
    applyStimulus("br_max",    0,   1,   BR_ALWAYS, ST_NONE, 32'hFFFFFFFF, 32'd0,        32'd0,  32'hFFFFFFFF, 1,  0,  0);
    applyStimulus("wrap",      0,   1,   BR_NONE,   ST_NONE, 32'd0,        32'd0,        32'd0,  32'd0,        0,  0,  0);
    applyStimulus("call500",   0,   1,   BR_NONE,   ST_CALL, 32'd500,      32'd0,        32'd0,  32'd500,      1,  1,  0);
    applyStimulus("rst_call",  1,   1,   BR_NONE,   ST_CALL, 32'd600,      32'd0,        32'd0,  32'd5,        0,  0,  0);
    applyStimulus("ret_post",  0,   1,   BR_NONE,   ST_RET,  32'd0,        32'd0,        32'd9,
                  EXC_EN ? EXC_VEC : 32'd9, 1, 0, EXC_EN);
    @(negedge clk);
    rst = 1'b0; step = 1'b0; branchOp = BR_NONE; stackOp = ST_NONE;
    for (int i = 0; i < 5 && expQ.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d pending required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle datapath. It replaces the fixed 32-bit PC update logic and adds an on-chip return-address stack (RAS), so CALL/RET no longer depend on a memory round trip. It also adds signed branch conditions, a stall/step enable, and a configurable reset vector. It sits between the control unit (branch/stack opcodes), the ALU (target address), the register file (condition operand) and instruction fetch (PC output).

## Interface
- PC_W, 32, PC and address width
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset
- EXC_VECTOR, 'h10, PC loaded on a RAS exception (used only with PC_RAS_EXC_EN)
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- step  in  1  advance PC this cycle; 0 = hold all state
- branch_op  in  3  000 none, 001 BR, 010 BPL, 011 BMI, 100 BZ, 101–111 reserved
- stack_op  in  3  000 none, 001 PUSH, 010 POP, 011 CALL, 100 RET, others reserved
- target  in  PC_W  branch/call target from the ALU
- regval  in  32  condition operand, signed two's complement
- mem_ret  in  PC_W  fallback return address from memory (LMD)
- pc  out  PC_W  current PC (registered)
- taken  out  1  last step redirected the PC (registered)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_full, ras_empty  out  1  RAS status (combinational from count)
- exc  out  1  one-cycle RAS fault pulse (present only with PC_RAS_EXC_EN)

## Operation
- A nonzero `branch_op` has priority; `stack_op` is ignored that step.
- BR: pc←target.
- BPL: jump when regval>0 (signed).
- BMI: jump when regval<0 (signed).
- BZ: jump when regval==0.
- Untaken branch: pc←pc+1.
- Reserved `branch_op` codes are treated as 000.
- PUSH, POP and reserved `stack_op` codes: pc←pc+1.
- CALL: push pc+1 onto the RAS, then pc←target.
- RET with RAS non-empty: pc←top of stack, then pop.
- RET with RAS empty: pc←mem_ret; count stays 0.
- CALL with RAS full: the oldest entry is overwritten (circular buffer) and count stays RAS_DEPTH.
- `taken` is 1 for BR, taken conditionals, CALL and RET; otherwise 0.
- PC arithmetic is modulo 2^PC_W: pc+1 wraps from all-ones to 0.
- RAS is LIFO, implemented as a circular buffer with a top pointer and a saturating count.

## Timing
- Reset values: pc=RESET_PC, taken=0, ras_count=0, ras_empty=1, ras_full=0, exc=0. RAS contents don't-care.
- Reset wins over `step` in the same cycle. Reset mid-sequence discards all RAS entries.
- Latency is one cycle: inputs sampled at the `step` edge appear on `pc` after that edge.
- `step`=0: pc, taken, RAS and exc hold. An exc pulse already driven deasserts on the next edge.
- Back-to-back CALL/RET on consecutive steps is supported. RET returns the address pushed by the immediately preceding CALL.

## Configuration
- PC_RAS_EXC_EN defined:
  - CALL on full RAS → no push, pc←EXC_VECTOR, exc=1 for one cycle.
  - RET on empty RAS → pc←EXC_VECTOR, exc=1; mem_ret is ignored.
  - taken=1 in both cases.
- PC_RAS_EXC_EN undefined:
  - Overwrite-oldest and mem_ret fallback behaviour as in Operation.
  - The `exc` port does not exist.

## Structure
- Package pc_pkg holds:
  - branch_op_t enum (BR_NONE, BR_ALWAYS, BR_PL, BR_MI, BR_Z)
  - stack_op_t enum (ST_NONE, ST_PUSH, ST_POP, ST_CALL, ST_RET)
  - opcode width constant (3)
- Sub-module pc_ras (params W, DEPTH):
  - Inputs: push, pop, push_data.
  - Outputs: top, count, full, empty.
  - Simultaneous push and pop is illegal and never issued by pc_sequencer.

## Test plan
- Reset with RESET_PC=5, then 3 steps with no op → pc 5,6,7,8; taken=0; ras_empty=1.
- BPL with regval=32'hFFFF_FFFF, target=40 → pc=pc+1 (signed negative). BMI with the same inputs → pc=40, taken=1.
- pc=10: CALL target=100, CALL target=200, RET, RET → pc 100, 200, 101, 11; ras_count 1,2,1,0.
- RAS_DEPTH=2: three CALLs from pc=0/100/200, then three RETs. Without the macro: returns 201, 101, then mem_ret. With the macro: 3rd CALL gives pc=EXC_VECTOR and exc pulse.
- pc=32'hFFFF_FFFF with no op → pc=0. Asserting rst during a CALL step → pc=RESET_PC, ras_count=0.
